// File: rtl/imem_port_arbiter.sv
// Instruction memory port arbiter: shares one 1-cycle-read memory port between fetch and loader.
// Optional loader starvation guard enabled by defining IMEM_STARVE_GUARD_EN.
module imem_port_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_boot_done,
   input  logic              i_if_req,
   input  logic [31:0]       i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_ld_req,
   input  logic              i_ld_we,
   input  logic [31:0]       i_ld_addr,
   input  logic [DATA_W-1:0] i_ld_wdata,
   output logic              o_ld_gnt,
   output logic              o_ld_rvalid,
   output logic [DATA_W-1:0] o_ld_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_err_align
);

   typedef enum logic {
      ST_BOOT,
      ST_RUN
   } state_t;

   state_t            r_state;
   logic              r_if_pend;
   logic              r_ld_pend;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_ld_rdata;
   logic              r_err_align;

   logic              w_force;
   logic              w_if_gnt;
   logic              w_ld_gnt;
   logic              w_any;
   logic [31:0]       w_addr;
   logic              w_misalign;

`ifdef IMEM_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] r_wait_cnt;

   assign w_force = (r_wait_cnt == CNT_W'(MAX_WAIT));

   // Count RUN cycles where the loader asks but loses; any grant or idle clears it
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || r_state != ST_RUN) begin
         r_wait_cnt <= '0;
      end else if (i_ld_req && !w_ld_gnt) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end
`else
   logic w_unused_cfg;

   assign w_force      = 1'b0;
   assign w_unused_cfg = (MAX_WAIT == 0);
`endif

   // Grant decision: loader owns the port in BOOT, fetch has priority in RUN
   always_comb begin
      w_if_gnt = 1'b0;
      w_ld_gnt = 1'b0;
      if (i_rst_n) begin
         if (r_state == ST_BOOT) begin
            w_ld_gnt = i_ld_req;
         end else begin
            w_if_gnt = i_if_req && !(w_force && i_ld_req);
            w_ld_gnt = i_ld_req && !w_if_gnt;
         end
      end
   end

   assign w_any      = w_if_gnt | w_ld_gnt;
   assign w_addr     = w_ld_gnt ? i_ld_addr : i_if_addr;
   assign w_misalign = w_any && (w_addr[1:0] != 2'b00);

   assign o_if_gnt    = w_if_gnt;
   assign o_ld_gnt    = w_ld_gnt;
   assign o_mem_en    = w_any;
   assign o_mem_we    = w_ld_gnt & i_ld_we;
   assign o_mem_addr  = w_any ? w_addr[ADDR_W+1:2] : '0;
   assign o_mem_wdata = (w_ld_gnt && i_ld_we) ? i_ld_wdata : '0;

   // Read data is live in the valid cycle, otherwise the last captured word
   assign o_if_rvalid = r_if_pend;
   assign o_ld_rvalid = r_ld_pend;
   assign o_if_rdata  = r_if_pend ? i_mem_rdata : r_if_rdata;
   assign o_ld_rdata  = r_ld_pend ? i_mem_rdata : r_ld_rdata;
   assign o_err_align = r_err_align;

   logic w_unused_addr;
   assign w_unused_addr = ^{i_if_addr[31:ADDR_W+2], i_ld_addr[31:ADDR_W+2]};

   // Boot sequencing: leave BOOT on boot_done, then stay in RUN until reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_BOOT;
      end else if (r_state == ST_BOOT && i_boot_done) begin
         r_state <= ST_RUN;
      end
   end

   // Track which side owns the read returning next cycle
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_if_pend <= 1'b0;
         r_ld_pend <= 1'b0;
      end else begin
         r_if_pend <= w_if_gnt;
         r_ld_pend <= w_ld_gnt & ~i_ld_we;
      end
   end

   // Capture returned words so each side holds its last read data
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_if_rdata <= '0;
         r_ld_rdata <= '0;
      end else begin
         if (r_if_pend) r_if_rdata <= i_mem_rdata;
         if (r_ld_pend) r_ld_rdata <= i_mem_rdata;
      end
   end

   // Sticky misalignment flag, cleared only by reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_err_align <= 1'b0;
      end else if (w_misalign) begin
         r_err_align <= 1'b1;
      end
   end

endmodule
